// File: rtl/uart_rx_ctrl_if.sv
// Bus bundle between uart_rx_ctrl, the UartRx core and the downstream byte consumer.
// master = the controller; slave = the core/consumer side.
interface uart_rx_ctrl_if #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]           RxData;
  logic                 RxReady;
  logic                 RxError;
  logic                 RxEnable;
  logic                 RxCoreReset;
  logic [7:0]           OutData;
  logic                 OutValid;
  logic                 OutReady;
  logic [LW-1:0]        Level;
  logic                 Overflow;
  logic                 ClearFlags;
  logic [CNT_WIDTH-1:0] ErrorCount;
  logic [CNT_WIDTH-1:0] DropCount;

  modport master (
    input  RxData, RxReady, RxError, OutReady, ClearFlags,
    output RxEnable, RxCoreReset, OutData, OutValid, Level, Overflow, ErrorCount, DropCount
  );

  modport slave (
    output RxData, RxReady, RxError, OutReady, ClearFlags,
    input  RxEnable, RxCoreReset, OutData, OutValid, Level, Overflow, ErrorCount, DropCount
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Sequencer for UartRx: acks bytes, buffers them in a FWFT FIFO, recovers the core by pulsing
// its reset. Define UART_RX_CTRL_STATS_EN to implement the ErrorCount/DropCount counters.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned RECOVER_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input logic            Clk,
  input logic            Reset,
  uart_rx_ctrl_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned RW = $clog2(RECOVER_CYCLES);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACK, S_RECOVER} ctrlState_e;

  ctrlState_e    state;
  logic [RW-1:0] recoverCnt;
  logic          rxEnable;
  logic          rxCoreReset;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [LW-1:0] level;
  logic          outValid;
  logic          overflow;

  logic enterRecover;
  logic pushReq;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Error outranks RxReady; a push only happens on the IDLE cycle that first sees RxReady.
  assign enterRecover = ((state == S_IDLE) || (state == S_ACK)) && bus.RxError;
  assign pushReq      = (state == S_IDLE) && !bus.RxError && bus.RxReady;
  assign full         = (level == LW'(DEPTH));
  assign pop          = outValid && bus.OutReady;
  assign push         = pushReq && (!full || pop);
  assign drop         = pushReq && full && !pop;

  // Control FSM; S_INIT and S_RECOVER share the timed core-reset pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= S_INIT;
      recoverCnt  <= '0;
      rxEnable    <= 1'b0;
      rxCoreReset <= 1'b0;
    end else if (enterRecover) begin
      state       <= S_RECOVER;
      recoverCnt  <= '0;
      rxEnable    <= 1'b0;
      rxCoreReset <= 1'b0;
    end else begin
      case (state)
        S_INIT, S_RECOVER: begin
          if (recoverCnt == RW'(RECOVER_CYCLES - 1)) begin
            recoverCnt  <= '0;
            rxCoreReset <= 1'b1;
            state       <= S_IDLE;
          end else begin
            recoverCnt <= recoverCnt + RW'(1);
          end
        end
        S_IDLE: begin
          if (bus.RxReady) begin
            rxEnable <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          if (!bus.RxReady) begin
            rxEnable <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wrPtr] <= bus.RxData;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      outValid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      if (push && !pop) begin
        level    <= level + LW'(1);
        outValid <= 1'b1;
      end else if (pop && !push) begin
        level    <= level - LW'(1);
        outValid <= (level != LW'(1));
      end
      if (bus.ClearFlags) overflow <= 1'b0;
      else if (drop)      overflow <= 1'b1;
    end
  end

`ifdef UART_RX_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] errorCount;
  logic [CNT_WIDTH-1:0] dropCount;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      errorCount <= '0;
      dropCount  <= '0;
    end else if (bus.ClearFlags) begin
      errorCount <= '0;
      dropCount  <= '0;
    end else begin
      if (enterRecover && (errorCount != '1)) errorCount <= errorCount + CNT_WIDTH'(1);
      if (drop && (dropCount != '1))          dropCount  <= dropCount + CNT_WIDTH'(1);
    end
  end

  assign bus.ErrorCount = errorCount;
  assign bus.DropCount  = dropCount;
`else
  assign bus.ErrorCount = '0;
  assign bus.DropCount  = '0;
`endif

  assign bus.RxEnable    = rxEnable;
  assign bus.RxCoreReset = rxCoreReset;
  assign bus.OutData     = mem[rdPtr];
  assign bus.OutValid    = outValid;
  assign bus.Level       = level;
  assign bus.Overflow    = overflow;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table, directed corner sequences and
// randomized byte traffic checked against a queue-based reference model.
module tb_uart_rx_ctrl;
  localparam int unsigned DEPTH = 8;
`ifdef UART_RX_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  uart_rx_ctrl_if #(.DEPTH(DEPTH), .CNT_WIDTH(8)) bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .RECOVER_CYCLES(16), .CNT_WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents plus sticky flag and counters.
  logic [7:0] mq[$];
  bit         mOvf = 1'b0;
  int         mDrop = 0;
  int         mErr = 0;

  typedef struct packed {
    logic       rdy;
    logic [7:0] data;
    logic       ordy;
    logic       clr;
    logic [3:0] lvl;
    logic       vld;
    logic [7:0] dat;
    logic       en;
    logic       ovf;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge; the model applies pop-then-push, error entry, and clear (clear wins).
  task automatic step(input bit pushEdge, input bit errEdge);
    bit popNow;
    popNow = (mq.size() != 0) && (bus.OutReady == 1'b1);
    @(posedge Clk);
    if (popNow) void'(mq.pop_front());
    if (pushEdge) begin
      if (mq.size() < DEPTH) mq.push_back(bus.RxData);
      else begin
        mOvf = 1'b1;
        if (mDrop < 255) mDrop++;
      end
    end
    if (errEdge && mErr < 255) mErr++;
    if (bus.ClearFlags) begin
      mOvf  = 1'b0;
      mDrop = 0;
      mErr  = 0;
    end
    #1;
  endtask

  task automatic checkModel(input string tag);
    chk({tag, ".level"}, 32'(bus.Level), 32'(mq.size()));
    chk({tag, ".valid"}, 32'(bus.OutValid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, ".data"}, 32'(bus.OutData), 32'(mq[0]));
    chk({tag, ".ovf"}, 32'(bus.Overflow), 32'(mOvf));
    chk({tag, ".drop"}, 32'(bus.DropCount), STATS ? 32'(mDrop) : 32'd0);
    chk({tag, ".err"}, 32'(bus.ErrorCount), STATS ? 32'(mErr) : 32'd0);
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, ".rxen"}, 32'(bus.RxEnable), 32'd0);
    chk({tag, ".corerst"}, 32'(bus.RxCoreReset), 32'd0);
    chk({tag, ".valid"}, 32'(bus.OutValid), 32'd0);
    chk({tag, ".level"}, 32'(bus.Level), 32'd0);
    chk({tag, ".ovf"}, 32'(bus.Overflow), 32'd0);
    chk({tag, ".err"}, 32'(bus.ErrorCount), 32'd0);
    chk({tag, ".drop"}, 32'(bus.DropCount), 32'd0);
  endtask

  // Counts clock edges until the core reset is released; bounded.
  task automatic waitRecover(input string tag, input bit randOr);
    int n;
    n = 0;
    while (bus.RxCoreReset == 1'b0 && n < 100) begin
      if (randOr) bus.OutReady = ($urandom_range(0, 9) < 3);
      step(1'b0, 1'b0);
      checkModel(tag);
      n++;
    end
    chk({tag, ".lowcycles"}, 32'(n), 32'd16);
    chk({tag, ".rxen"}, 32'(bus.RxEnable), 32'd0);
  endtask

  // One full RxReady episode starting from idle.
  task automatic deliver(input logic [7:0] d, input int hold, input bit randOr);
    bus.RxData  = d;
    bus.RxReady = 1'b1;
    if (randOr) bus.OutReady = ($urandom_range(0, 9) < 3);
    step(1'b1, 1'b0);
    checkModel("push");
    chk("rxen.rise", 32'(bus.RxEnable), 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (randOr) bus.OutReady = ($urandom_range(0, 9) < 3);
      step(1'b0, 1'b0);
      checkModel("ack");
      chk("rxen.hold", 32'(bus.RxEnable), 32'd1);
    end
    bus.RxReady = 1'b0;
    if (randOr) bus.OutReady = ($urandom_range(0, 9) < 3);
    step(1'b0, 1'b0);
    checkModel("release");
    chk("rxen.fall", 32'(bus.RxEnable), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 4'd1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 4'd1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 4'd1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 4'd2, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h3C, 1'b0, 1'b0, 4'd2, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 4'd1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 4'd1, 1'b1, 8'h77, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h77, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};

    bus.RxData     = 8'h00;
    bus.RxReady    = 1'b0;
    bus.RxError    = 1'b0;
    bus.OutReady   = 1'b0;
    bus.ClearFlags = 1'b0;
    Reset          = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkResetVals("por");

    // Power-up: core held in reset for 16 cycles after release.
    Reset = 1'b1;
    waitRecover("init", 1'b0);

    // Table: single-byte handshake, FWFT head, simultaneous push/pop, empty pop.
    for (int i = 0; i < 11; i++) begin
      bus.RxReady    = vecs[i].rdy;
      bus.RxData     = vecs[i].data;
      bus.OutReady   = vecs[i].ordy;
      bus.ClearFlags = vecs[i].clr;
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d.level", i), 32'(bus.Level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d.valid", i), 32'(bus.OutValid), 32'(vecs[i].vld));
      if (vecs[i].vld) chk($sformatf("vec%0d.data", i), 32'(bus.OutData), 32'(vecs[i].dat));
      chk($sformatf("vec%0d.rxen", i), 32'(bus.RxEnable), 32'(vecs[i].en));
      chk($sformatf("vec%0d.ovf", i), 32'(bus.Overflow), 32'(vecs[i].ovf));
    end
    bus.RxReady    = 1'b0;
    bus.OutReady   = 1'b0;
    bus.ClearFlags = 1'b0;

    // Nine bytes into an 8-deep FIFO with no consumer: last one dropped.
    for (int i = 0; i < 9; i++) deliver(8'(8'h10 + i), 1, 1'b0);
    chk("full.level", 32'(bus.Level), 32'd8);
    chk("full.ovf", 32'(bus.Overflow), 32'd1);
    chk("full.drop", 32'(bus.DropCount), STATS ? 32'd1 : 32'd0);

    // Error in idle: recovery keeps the FIFO intact.
    bus.RxError = 1'b1;
    step(1'b0, 1'b1);
    bus.RxError = 1'b0;
    checkModel("errIdle.entry");
    chk("errIdle.corerst", 32'(bus.RxCoreReset), 32'd0);
    chk("errIdle.count", 32'(bus.ErrorCount), STATS ? 32'd1 : 32'd0);
    waitRecover("errIdle", 1'b0);
    chk("errIdle.level", 32'(bus.Level), 32'd8);

    // Drain in order.
    bus.OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.data", i), 32'(bus.OutData), 32'(8'h10 + i));
      step(1'b0, 1'b0);
      checkModel("drain");
    end
    bus.OutReady = 1'b0;
    chk("drained.level", 32'(bus.Level), 32'd0);

    // Error while in ACK: byte already pushed is kept, no push during recovery.
    bus.RxData  = 8'h5A;
    bus.RxReady = 1'b1;
    step(1'b1, 1'b0);
    checkModel("errAck.push");
    chk("errAck.rxen", 32'(bus.RxEnable), 32'd1);
    bus.RxError = 1'b1;
    step(1'b0, 1'b1);
    checkModel("errAck.entry");
    chk("errAck.rxenoff", 32'(bus.RxEnable), 32'd0);
    chk("errAck.corerst", 32'(bus.RxCoreReset), 32'd0);
    chk("errAck.count", 32'(bus.ErrorCount), STATS ? 32'd2 : 32'd0);
    bus.RxError = 1'b0;
    bus.RxReady = 1'b0;
    waitRecover("errAck", 1'b0);
    chk("errAck.level", 32'(bus.Level), 32'd1);

    bus.ClearFlags = 1'b1;
    step(1'b0, 1'b0);
    bus.ClearFlags = 1'b0;
    checkModel("clear");
    chk("clear.err", 32'(bus.ErrorCount), 32'd0);
    chk("clear.ovf", 32'(bus.Overflow), 32'd0);

    // Full FIFO with a same-cycle pop: push accepted, no overflow.
    for (int i = 0; i < 7; i++) deliver(8'(8'h20 + i), 0, 1'b0);
    chk("fill.level", 32'(bus.Level), 32'd8);
    bus.RxData   = 8'hC3;
    bus.RxReady  = 1'b1;
    bus.OutReady = 1'b1;
    step(1'b1, 1'b0);
    checkModel("fullpop");
    chk("fullpop.level", 32'(bus.Level), 32'd8);
    chk("fullpop.ovf", 32'(bus.Overflow), 32'd0);
    bus.OutReady = 1'b0;
    step(1'b0, 1'b0);
    bus.RxReady = 1'b0;
    step(1'b0, 1'b0);
    checkModel("fullpop.rel");
    bus.OutReady = 1'b1;
    for (int i = 0; i < 20 && mq.size() != 0; i++) begin
      step(1'b0, 1'b0);
      checkModel("fullpop.drain");
    end
    bus.OutReady = 1'b0;

    // Reset asserted mid-ACK with three entries.
    deliver(8'h61, 0, 1'b0);
    deliver(8'h62, 0, 1'b0);
    bus.RxData  = 8'h63;
    bus.RxReady = 1'b1;
    step(1'b1, 1'b0);
    chk("midrst.pre.level", 32'(bus.Level), 32'd3);
    chk("midrst.pre.rxen", 32'(bus.RxEnable), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    checkResetVals("midrst");
    mq.delete();
    mOvf  = 1'b0;
    mDrop = 0;
    mErr  = 0;
    bus.RxReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    waitRecover("reinit", 1'b0);

    // Randomized traffic against the model.
    for (int e = 0; e < 150; e++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        bus.OutReady   = ($urandom_range(0, 9) < 3);
        bus.ClearFlags = ($urandom_range(0, 19) == 0);
        step(1'b0, 1'b0);
        checkModel("rgap");
      end
      bus.ClearFlags = 1'b0;
      if ($urandom_range(0, 24) == 0) begin
        bus.RxError = 1'b1;
        step(1'b0, 1'b1);
        bus.RxError = 1'b0;
        checkModel("rerr.entry");
        waitRecover("rerr", 1'b1);
      end else begin
        deliver(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
